// File: rtl/instruction_execute_if.sv
// Decode-to-execute handshake plus the execute stage's memory and branch result buses.
interface instruction_execute_if;
  logic [151:0] ID_output;
  logic         ID_valid;
  logic         stall;
  logic [78:0]  Address_Value_RegAddress_isLoad_isMemWrite_isWrite;
  logic [8:0]   Branch_Update_with_isBranch;

  modport master (
    output ID_output, ID_valid,
    input  stall, Address_Value_RegAddress_isLoad_isMemWrite_isWrite, Branch_Update_with_isBranch
  );
  modport slave (
    input  ID_output, ID_valid,
    output stall, Address_Value_RegAddress_isLoad_isMemWrite_isWrite, Branch_Update_with_isBranch
  );
endinterface

// File: rtl/instruction_execute.sv
// Execute stage: single-cycle ALU/address/branch ops and a 64-step shift-add multiplier
// that stalls decode while it iterates.
module instruction_execute (
  input logic                 clk,
  input logic                 reset,
  instruction_execute_if.slave ex
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]  r_state;
  logic        r_flush;
  logic [78:0] r_av;
  logic [8:0]  r_br;
  logic [63:0] r_mcand, r_mplier, r_acc;
  logic [5:0]  r_count;
  logic [3:0]  r_dest;

  logic [3:0]  w_op, w_dest;
  logic [63:0] w_a, w_b, w_val;
  logic [7:0]  w_imm, w_pc, w_addr;
  logic [78:0] w_av;
  logic [8:0]  w_br;
  logic        w_start_mul;
  logic [63:0] w_acc_next;

  assign w_op   = ex.ID_output[3:0];
  assign w_a    = ex.ID_output[67:4];
  assign w_b    = ex.ID_output[131:68];
  assign w_imm  = ex.ID_output[139:132];
  assign w_dest = ex.ID_output[143:140];
  assign w_pc   = ex.ID_output[151:144];
  assign w_addr = w_a[7:0] + w_imm;

  always_comb begin
    w_val       = '0;
    w_av        = '0;
    w_br        = '0;
    w_start_mul = 1'b0;
    case (w_op)
      4'd1:  w_val = w_a + w_b;
      4'd2:  w_val = w_a - w_b;
      4'd3:  w_val = w_a & w_b;
      4'd4:  w_val = w_a | w_b;
      4'd5:  w_val = w_a ^ w_b;
      4'd6:  w_val = w_a << w_b[5:0];
      4'd7:  w_val = w_a >> w_b[5:0];
      4'd8:  w_val = w_a + {56'h0, w_imm};
      default: w_val = '0;
    endcase
    case (w_op)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8:
        w_av = {3'b100, w_dest, w_val, 8'h00};
      4'd9:  w_av = {3'b101, w_dest, 64'h0, w_addr};
      4'd10: w_av = {3'b010, 4'h0, w_b, w_addr};
      4'd11: if (w_a == w_b) w_br = {1'b1, w_pc + w_imm};
      4'd12: w_br = {1'b1, w_imm};
      4'd13: w_start_mul = 1'b1;
      default: ;
    endcase
  end

  // Final step's partial product is folded into the written-back result.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 64'h0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_flush  <= 1'b0;
      r_av     <= '0;
      r_br     <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_dest   <= '0;
    end else begin
      r_br <= '0;
      case (r_state)
        S_IDLE: begin
          r_av <= '0;
          if (ex.ID_valid) begin
            if (r_flush) begin
              r_flush <= 1'b0;
            end else begin
              r_av    <= w_av;
              r_br    <= w_br;
              r_flush <= w_br[8];
              if (w_start_mul) begin
                r_mcand  <= w_a;
                r_mplier <= w_b;
                r_dest   <= w_dest;
                r_acc    <= '0;
                r_count  <= '0;
                r_state  <= S_MUL;
              end
            end
          end
        end
        default: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 6'd1;
          r_av     <= '0;
          if (r_count == 6'd63) begin
            r_av    <= {3'b100, r_dest, w_acc_next, 8'h00};
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign ex.stall = (r_state == S_MUL);
  assign ex.Address_Value_RegAddress_isLoad_isMemWrite_isWrite = r_av;
  assign ex.Branch_Update_with_isBranch = r_br;
endmodule

// File: tb/tb_instruction_execute.sv
// Directed and randomized checks of instruction_execute against an arithmetic reference model.
module tb_instruction_execute;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  instruction_execute_if ifc ();
  instruction_execute dut (.clk(clk), .reset(reset), .ex(ifc.slave));

  always #5 clk = ~clk;

  // reference model state: busy_left counts remaining multiply edges
  logic [78:0] m_av;
  logic [8:0]  m_br;
  logic        m_flush;
  int          m_busy_left;
  logic [63:0] m_mul_res;
  logic [3:0]  m_mul_dest;

  task automatic chk(input string tag, input logic [78:0] obs, input logic [78:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_av = '0; m_br = '0; m_flush = 1'b0; m_busy_left = 0; m_mul_res = '0; m_mul_dest = '0;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [7:0] imm, input logic [3:0] d,
                            input logic [7:0] pc);
    logic [7:0]  addr;
    logic [63:0] prod;
    addr = a[7:0] + imm;
    m_br = '0;
    m_av = '0;
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) m_av = {3'b100, m_mul_dest, m_mul_res, 8'h00};
      return;
    end
    if (!v) return;
    if (m_flush) begin
      m_flush = 1'b0;
      return;
    end
    case (op)
      4'd1:  m_av = {3'b100, d, a + b, 8'h00};
      4'd2:  m_av = {3'b100, d, a - b, 8'h00};
      4'd3:  m_av = {3'b100, d, a & b, 8'h00};
      4'd4:  m_av = {3'b100, d, a | b, 8'h00};
      4'd5:  m_av = {3'b100, d, a ^ b, 8'h00};
      4'd6:  m_av = {3'b100, d, a << (b % 64), 8'h00};
      4'd7:  m_av = {3'b100, d, a >> (b % 64), 8'h00};
      4'd8:  m_av = {3'b100, d, a + 64'(imm), 8'h00};
      4'd9:  m_av = {3'b101, d, 64'h0, addr};
      4'd10: m_av = {3'b010, 4'h0, b, addr};
      4'd11: if (a == b) begin m_br = {1'b1, pc + imm}; m_flush = 1'b1; end
      4'd12: begin m_br = {1'b1, imm}; m_flush = 1'b1; end
      4'd13: begin
        prod = a * b;
        m_mul_res = prod;
        m_mul_dest = d;
        m_busy_left = 64;
      end
      default: ;
    endcase
  endtask

  // Drive at the falling edge, model the rising edge, compare at the next falling edge.
  task automatic step(input string tag, input logic v, input logic [3:0] op,
                      input logic [63:0] a, input logic [63:0] b, input logic [7:0] imm,
                      input logic [3:0] d, input logic [7:0] pc);
    ifc.ID_valid  = v;
    ifc.ID_output = {pc, d, imm, b, a, op};
    @(posedge clk);
    model_edge(v, op, a, b, imm, d, pc);
    @(negedge clk);
    chk({tag, ".av"}, ifc.Address_Value_RegAddress_isLoad_isMemWrite_isWrite, m_av);
    chk({tag, ".br"}, 79'(ifc.Branch_Update_with_isBranch), 79'(m_br));
    chk({tag, ".stall"}, 79'(ifc.stall), 79'(m_busy_left > 0));
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk({tag, ".av"}, ifc.Address_Value_RegAddress_isLoad_isMemWrite_isWrite, 79'h0);
    chk({tag, ".br"}, 79'(ifc.Branch_Update_with_isBranch), 79'h0);
    chk({tag, ".stall"}, 79'(ifc.stall), 79'h0);
    #1 reset = 1'b0;
  endtask

  initial begin
    ifc.ID_valid = 1'b0;
    ifc.ID_output = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.av", ifc.Address_Value_RegAddress_isLoad_isMemWrite_isWrite, 79'h0);
    chk("rst.br", 79'(ifc.Branch_Update_with_isBranch), 79'h0);
    chk("rst.stall", 79'(ifc.stall), 79'h0);
    reset = 1'b0;

    step("add", 1, 4'd1, 64'd5, 64'd7, 8'h0, 4'd6, 8'h0);
    chk("add.const", ifc.Address_Value_RegAddress_isLoad_isMemWrite_isWrite,
        {3'b100, 4'd6, 64'd12, 8'h00});
    async_reset("midrst");
    step("sub_wrap", 1, 4'd2, 64'd0, 64'd1, 8'h0, 4'd2, 8'h0);
    step("shl70", 1, 4'd6, 64'd1, 64'd70, 8'h0, 4'd3, 8'h0);
    chk("shl70.const", ifc.Address_Value_RegAddress_isLoad_isMemWrite_isWrite,
        {3'b100, 4'd3, 64'd64, 8'h00});
    step("load", 1, 4'd9, 64'h10, 64'h0, 8'h01, 4'd3, 8'h0);
    step("store", 1, 4'd10, 64'hFF, 64'd3, 8'h03, 4'd0, 8'h0);
    chk("store.const", ifc.Address_Value_RegAddress_isLoad_isMemWrite_isWrite,
        {3'b010, 4'd0, 64'd3, 8'h02});
    step("beq_t", 1, 4'd11, 64'd9, 64'd9, 8'h04, 4'd0, 8'hFE);
    chk("beq_t.const", 79'(ifc.Branch_Update_with_isBranch), 79'h102);
    step("bub", 0, 4'd1, 64'd1, 64'd1, 8'h0, 4'd1, 8'h0);
    step("squash", 1, 4'd1, 64'd1, 64'd2, 8'h0, 4'd1, 8'h0);
    step("after", 1, 4'd1, 64'd1, 64'd2, 8'h0, 4'd1, 8'h0);
    step("beq_nt", 1, 4'd11, 64'd1, 64'd2, 8'h04, 4'd0, 8'h10);
    step("nosq", 1, 4'd3, 64'hF0F0, 64'hFF00, 8'h0, 4'd4, 8'h0);

    step("mul", 1, 4'd13, 64'hFFFF_FFFF, 64'h1_0000_0001, 8'h0, 4'd9, 8'h0);
    for (int i = 1; i <= 64; i++)
      step("mulbusy", 1, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
           8'($urandom), 4'($urandom), 8'($urandom));
    chk("mul.const", ifc.Address_Value_RegAddress_isLoad_isMemWrite_isWrite,
        {3'b100, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00});

    step("mul2", 1, 4'd13, 64'd3, 64'd5, 8'h0, 4'd1, 8'h0);
    for (int i = 1; i < 30; i++) step("mul2busy", 0, 4'd0, 64'd0, 64'd0, 8'h0, 4'd0, 8'h0);
    async_reset("mulrst");
    step("postrst_add", 1, 4'd1, 64'd100, 64'd23, 8'h0, 4'd5, 8'h0);
    step("postrst_idle", 0, 4'd0, 64'd0, 64'd0, 8'h0, 4'd0, 8'h0);

    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic [63:0] a, b;
      op = 4'($urandom_range(0, 15));
      if (op == 4'd13 && $urandom_range(0, 3) != 0) op = 4'd1;
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 1) != 0) ? a : {$urandom, $urandom};
      step("rnd", $urandom_range(0, 7) != 0, op, a, b, 8'($urandom), 4'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
